// File: rtl/serial_pkg.sv
// serial_pkg: opcodes and multiply phase encoding shared by the serial sequencer
// Contents:
//   OP_*    3-bit instruction opcodes (ADD occupies both 100 and 101)
//   phase_t multiply phase; 2'b10 is unused and decoded as PH_SIGN
package serial_pkg;

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_STALL    = 3'b001;
    localparam logic [2:0] OP_MUL_D    = 3'b010;
    localparam logic [2:0] OP_MUL_1MD  = 3'b011;
    localparam logic [2:0] OP_ADD      = 3'b100;
    localparam logic [2:0] OP_WAIT_REL = 3'b110;
    localparam logic [2:0] OP_LOAD     = 3'b111;

    typedef enum logic [1:0] {
        PH_SIGN  = 2'b00,
        PH_ALIGN = 2'b01,
        PH_MUL   = 2'b11
    } phase_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op == OP_MUL_D || op == OP_MUL_1MD;
    endfunction

endpackage

// File: rtl/serial_seq_ctrl_bit_counter.sv
// bit_counter: bit index counter that wraps explicitly at DATA_W-1
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset, clears the count
//   i_en   advance the count by one (wrapping after DATA_W-1)
//   i_clr  synchronous clear, has priority over i_en
//   o_cnt  current bit index
//   o_last count is at DATA_W-1
module bit_counter #(
    parameter int DATA_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_clr,
    output logic [$clog2(DATA_W)-1:0] o_cnt,
    output logic                      o_last
);

    localparam int CW = $clog2(DATA_W);

    // Explicit wrap: DATA_W need not be a power of two
    assign o_last = o_cnt == CW'(DATA_W - 1);

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_en)
            o_cnt <= o_last ? '0 : o_cnt + 1'b1;

endmodule

// File: rtl/serial_seq_ctrl.sv
// serial_seq_ctrl: instruction decoder and bit/phase sequencer for the bit-serial datapath
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_instr                 current opcode
//   i_start                 synchronised start/run switch
//   i_en                    bit-step enable; nothing advances and every strobe is 0 when low
//   o_bit_sel               current bit index
//   o_con_*                 datapath mux / shift / sign / retire strobes
//   o_phase                 multiply phase
//   o_busy                  a bit sequence or multiply is in progress
module serial_seq_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CNT_W         = $clog2(DATA_W),
    parameter int ALIGN_GPR_D   = 2,
    parameter int ALIGN_GPR_1MD = 1,
    parameter int ALIGN_ACC     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_instr,
    input  logic             i_start,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_bit_sel,
    output logic             o_con_mux,
    output logic             o_con_muxalu,
    output logic             o_con_gpr_shift,
    output logic             o_con_acc_shift,
    output logic             o_con_gpr_sign,
    output logic             o_con_acc_sign,
    output logic             o_con_sign_store,
    output logic             o_con_pcincr,
    output logic [1:0]       o_phase,
    output logic             o_busy
);

    phase_t           phase;
    phase_t           ph;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             is_mul;
    logic             is_cnt_op;
    logic             is_ctl_op;
    logic             mux, muxalu, gpr_shift, acc_shift, gpr_sign, acc_sign, sign_store, pcincr;
    int               align_gpr;

    assign is_mul    = is_mul_op(i_instr);
    assign is_cnt_op = is_mul || i_instr[2:1] == OP_ADD[2:1] || i_instr == OP_LOAD;
    assign is_ctl_op = !is_cnt_op;
    assign align_gpr = i_instr == OP_MUL_D ? ALIGN_GPR_D : ALIGN_GPR_1MD;

    // The unused encoding 2'b10 behaves exactly like PH_SIGN
    assign ph = (phase == PH_ALIGN || phase == PH_MUL) ? phase : PH_SIGN;

    bit_counter #(.DATA_W(DATA_W)) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en && is_cnt_op),
        .i_clr  (is_ctl_op && o_con_pcincr),
        .o_cnt  (cnt),
        .o_last (last)
    );

    always_comb begin
        mux        = 1'b0;
        muxalu     = 1'b0;
        gpr_shift  = 1'b0;
        acc_shift  = 1'b0;
        gpr_sign   = 1'b0;
        acc_sign   = 1'b0;
        sign_store = 1'b0;
        pcincr     = 1'b0;
        case (i_instr)
            OP_NOP:      pcincr = i_start;
            OP_STALL:    pcincr = 1'b1;
            OP_WAIT_REL: pcincr = !i_start;
            OP_LOAD: begin
                mux       = 1'b1;
                gpr_shift = 1'b1;
                pcincr    = last;
            end
            OP_MUL_D, OP_MUL_1MD: begin
                muxalu     = ph == PH_SIGN;
                gpr_sign   = ph == PH_ALIGN;
                acc_sign   = ph == PH_ALIGN;
                sign_store = ph == PH_SIGN && last;
                pcincr     = ph == PH_MUL && last;
                // Align phase shifts only the first few bits to line up the operands
                gpr_shift  = ph != PH_ALIGN || int'(cnt) < align_gpr;
                acc_shift  = ph != PH_ALIGN || int'(cnt) < ALIGN_ACC;
            end
            default: begin
                gpr_shift = 1'b1;
                acc_shift = 1'b1;
                pcincr    = last;
            end
        endcase
    end

    assign o_con_mux        = i_en && mux;
    assign o_con_muxalu     = i_en && muxalu;
    assign o_con_gpr_shift  = i_en && gpr_shift;
    assign o_con_acc_shift  = i_en && acc_shift;
    assign o_con_gpr_sign   = i_en && gpr_sign;
    assign o_con_acc_sign   = i_en && acc_sign;
    assign o_con_sign_store = i_en && sign_store;
    assign o_con_pcincr     = i_en && pcincr;

    // Phase steps SIGN -> ALIGN -> MUL -> SIGN on the last bit of each word;
    // any non-multiply step (or the unused encoding) lands back in PH_SIGN.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            phase <= PH_SIGN;
        else if (i_en)
            phase <= !is_mul ? PH_SIGN :
                     !last ? ph :
                     ph == PH_SIGN ? PH_ALIGN :
                     ph == PH_ALIGN ? PH_MUL : PH_SIGN;

    assign o_bit_sel = cnt;
    assign o_phase   = phase;
    assign o_busy    = phase != PH_SIGN || cnt != '0;

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// tb_serial_seq_ctrl: randomized and directed checks of serial_seq_ctrl (DATA_W 8 and 6) against a progress-count model
module tb_serial_seq_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [2:0] i_instr = 3'b000;
    logic       i_start = 1'b0;
    logic       i_en = 1'b0;

    logic [2:0] bs8, bs6;
    logic [1:0] ph8, ph6;
    logic       mx8, ma8, gs8, as8, gg8, ag8, ss8, pc8, by8;
    logic       mx6, ma6, gs6, as6, gg6, ag6, ss6, pc6, by6;

    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    serial_seq_ctrl #(.DATA_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_start(i_start), .i_en(i_en),
        .o_bit_sel(bs8), .o_con_mux(mx8), .o_con_muxalu(ma8), .o_con_gpr_shift(gs8),
        .o_con_acc_shift(as8), .o_con_gpr_sign(gg8), .o_con_acc_sign(ag8),
        .o_con_sign_store(ss8), .o_con_pcincr(pc8), .o_phase(ph8), .o_busy(by8)
    );

    serial_seq_ctrl #(.DATA_W(6)) dut6 (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_start(i_start), .i_en(i_en),
        .o_bit_sel(bs6), .o_con_mux(mx6), .o_con_muxalu(ma6), .o_con_gpr_shift(gs6),
        .o_con_acc_shift(as6), .o_con_gpr_sign(gg6), .o_con_acc_sign(ag6),
        .o_con_sign_store(ss6), .o_con_pcincr(pc6), .o_phase(ph6), .o_busy(by6)
    );

    // {bit_sel[2:0], mux, muxalu, gpr_shift, acc_shift, gpr_sign, acc_sign, sign_store, pcincr, phase[1:0], busy}
    logic [13:0] act8, act6, exp8, exp6;
    assign act8 = {bs8, mx8, ma8, gs8, as8, gg8, ag8, ss8, pc8, ph8, by8};
    assign act6 = {bs6, mx6, ma6, gs6, as6, gg6, ag6, ss6, pc6, ph6, by6};

    // Model state k: number of enabled steps into the current word sequence.
    // For a multiply k runs 0..3W-1 (phase = k/W, bit = k%W); other ops keep k < W.
    int m8 = 0;
    int m6 = 0;

    function automatic logic [13:0] expf(input int k, input int w, input logic [2:0] ins,
                                         input logic en, input logic st);
        int c = k % w;
        int p = k / w;
        logic [7:0] con = '0;
        logic [1:0] pc = p == 0 ? 2'b00 : p == 1 ? 2'b01 : 2'b11;
        // con = {mux, muxalu, gs, as, gsg, asg, ss, pc}
        if (en) begin
            if (ins == 3'd0) con[0] = st;
            else if (ins == 3'd1) con[0] = 1'b1;
            else if (ins == 3'd6) con[0] = !st;
            else if (ins == 3'd4 || ins == 3'd5) con = {4'b0011, 3'b000, c == w - 1};
            else if (ins == 3'd7) con = {4'b1010, 3'b000, c == w - 1};
            else if (p == 0) con = {4'b0111, 2'b00, k == w - 1, 1'b0};
            else if (p == 2) con = {4'b0011, 3'b000, k == 3 * w - 1};
            else con = {2'b00, c < (ins == 3'd2 ? 2 : 1), c < 3, 4'b1100};
        end
        return {3'(c), con, pc, k != 0};
    endfunction

    function automatic int nextk(input int k, input int w, input logic [2:0] ins,
                                 input logic en, input logic st);
        if (!en) return k;
        if (ins == 3'd2 || ins == 3'd3) return (k + 1) % (3 * w);
        if (ins >= 3'd4 && ins != 3'd6) return (k % w + 1) % w;
        if (ins == 3'd1 || (ins == 3'd0 && st) || (ins == 3'd6 && !st)) return 0;
        return k % w;
    endfunction

    assign exp8 = expf(m8, 8, i_instr, i_en, i_start);
    assign exp6 = expf(m6, 6, i_instr, i_en, i_start);

    always @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            m8 <= 0;
            m6 <= 0;
        end else begin
            m8 <= nextk(m8, 8, i_instr, i_en, i_start);
            m6 <= nextk(m6, 6, i_instr, i_en, i_start);
        end

    task automatic step(input logic [2:0] ins, input logic en, input logic st);
        @(negedge i_clk);
        i_instr = ins;
        i_en = en;
        i_start = st;
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_en = 1'b0;
        i_instr = 3'd0;
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_en = 1'b1;
        i_instr = 3'd2;
        #1;
        n_chk++;
        if ({bs8, ph8, by8} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 000000", {bs8, ph8, by8});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_en = 1'b0;
        #1;
        n_chk++;
        if (act8 !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", act8);
        end
    endtask

    task automatic test_load();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(3'd7, 1'b1, 1'b0);
            n_chk++;
            if (bs8 !== 3'(i) || mx8 !== 1'b1 || pc8 !== (i == 7)) begin
                n_fail++;
                $display("FAIL load_cycle%0d: bit_sel=%0d mux=%b pc=%b expected %0d 1 %b", i, bs8, mx8, pc8, i, i == 7);
            end
            n_chk++;
            if (act8 !== exp8) begin
                n_fail++;
                $display("FAIL load_model%0d: got %b expected %b", i, act8, exp8);
            end
        end
        step(3'd0, 1'b0, 1'b0);
        n_chk++;
        if (bs8 !== 3'd0 || by8 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wrap: bit_sel=%0d busy=%b expected 0 0", bs8, by8);
        end
    endtask

    task automatic test_mul_d();
        logic [1:0] eph;
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            step(3'd2, 1'b1, 1'b0);
            eph = i <= 8 ? 2'b00 : i <= 16 ? 2'b01 : 2'b11;
            n_chk++;
            if (ss8 !== (i == 8) || pc8 !== (i == 24) || gs8 !== (i <= 8 || i >= 17 || i <= 10)
                || as8 !== (i <= 8 || i >= 17 || i <= 11) || {gg8, ag8} !== {2{i >= 9 && i <= 16}} || ph8 !== eph) begin
                n_fail++;
                $display("FAIL mul_d_cycle%0d: ss=%b pc=%b gs=%b as=%b signs=%b%b phase=%b expected %b %b phase %b",
                         i, ss8, pc8, gs8, as8, gg8, ag8, ph8, i == 8, i == 24, eph);
            end
        end
        step(3'd0, 1'b0, 1'b0);
        n_chk++;
        if (ph8 !== 2'b00 || by8 !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_d_end: phase=%b busy=%b expected 00 0", ph8, by8);
        end
    endtask

    task automatic test_mul_1md_toggle();
        int en_cnt = 0;
        int al_cnt = 0;
        bit done = 0;
        do_reset();
        for (int i = 0; i < 100 && !done; i++) begin
            step(3'd3, (i % 2) == 0, 1'b0);
            if (!i_en) begin
                n_chk++;
                if (act8[10:3] !== 8'b0) begin
                    n_fail++;
                    $display("FAIL mul_1md_disabled%0d: con=%b expected 00000000", i, act8[10:3]);
                end
            end else begin
                en_cnt++;
                if (gs8 && gg8) al_cnt++;
                done = pc8;
            end
        end
        n_chk++;
        if (en_cnt !== 24 || !done) begin
            n_fail++;
            $display("FAIL mul_1md_len: enabled cycles=%0d done=%b expected 24 1", en_cnt, done);
        end
        n_chk++;
        if (al_cnt !== 1) begin
            n_fail++;
            $display("FAIL mul_1md_align: gpr shifts=%0d expected 1", al_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        repeat (11) step(3'd2, 1'b1, 1'b0);
        step(3'd2, 1'b0, 1'b0);
        n_chk++;
        if (ph8 !== 2'b01 || bs8 !== 3'd3) begin
            n_fail++;
            $display("FAIL arst_pre: phase=%b bit_sel=%0d expected 01 3", ph8, bs8);
        end
        #1 i_rst = 1'b1;
        #1;
        n_chk++;
        if (ph8 !== 2'b00 || bs8 !== 3'd0 || by8 !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: phase=%b bit_sel=%0d busy=%b expected 00 0 0", ph8, bs8, by8);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step(3'd2, 1'b1, 1'b0);
            if (pc8) n = i;
        end
        n_chk++;
        if (n !== 24) begin
            n_fail++;
            $display("FAIL arst_restart: pcincr at cycle %0d expected 24", n);
        end
    endtask

    task automatic test_add_w6();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(i % 2 ? 3'd5 : 3'd4, 1'b1, 1'b0);
            n_chk++;
            if (bs6 !== 3'(i % 6) || pc6 !== (i % 6 == 5)) begin
                n_fail++;
                $display("FAIL add6_cycle%0d: bit_sel=%0d pc=%b expected %0d %b", i, bs6, pc6, i % 6, i % 6 == 5);
            end
        end
    endtask

    task automatic test_nop_wait();
        do_reset();
        repeat (5) begin
            step(3'd0, 1'b1, 1'b0);
            n_chk++;
            if (pc8 !== 1'b0) begin
                n_fail++;
                $display("FAIL nop_idle: pc=%b expected 0", pc8);
            end
        end
        step(3'd0, 1'b1, 1'b1);
        n_chk++;
        if (pc8 !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_start: pc=%b expected 1", pc8);
        end
        repeat (3) begin
            step(3'd6, 1'b1, 1'b1);
            n_chk++;
            if (pc8 !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: pc=%b expected 0", pc8);
            end
        end
        step(3'd6, 1'b1, 1'b0);
        n_chk++;
        if (pc8 !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_release: pc=%b expected 1", pc8);
        end
    endtask

    task automatic test_random();
        logic [2:0] ins;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            // Bias toward multiplies so long sequences actually complete
            ins = $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
            step(ins, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            n_chk++;
            if (act8 !== exp8) begin
                n_fail++;
                $display("FAIL rand8_%0d: instr=%0d got %b expected %b", i, ins, act8, exp8);
            end
            n_chk++;
            if (act6 !== exp6) begin
                n_fail++;
                $display("FAIL rand6_%0d: instr=%0d got %b expected %b", i, ins, act6, exp6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_mul_d();
        test_mul_1md_toggle();
        test_async_reset();
        test_add_w6();
        test_nop_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_seq_ctrl.md
Name: serial_seq_ctrl

Overview:
Parametrised control sequencer for the bit-serial datapath. It decodes the 3-bit instruction from the program counter/ROM and owns a wrap-at-DATA_W bit counter and a multiply phase register. It drives the datapath mux, shift, sign and PC-increment strobes. It extends the 8-bit decoder with the following:
- configurable word width;
- configurable alignment-shift counts;
- a bit-step enable;
- busy/phase status outputs;
- fully registered state with asynchronous reset.

Parameters:
DATA_W, 8, serial word width in bits (>=4, need not be a power of 2)
CNT_W, $clog2(DATA_W), bit-counter width (derived; do not override)
ALIGN_GPR_D, 2, GPR shift cycles in the align phase for MUL_D
ALIGN_GPR_1MD, 1, GPR shift cycles in the align phase for MUL_1MD
ALIGN_ACC, 3, ACC shift cycles in the align phase (both multiplies)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_instr  in  3  current opcode
i_start  in  1  start/run switch, already synchronised
i_en  in  1  bit-step enable; state advances only when 1
o_bit_sel  out  CNT_W  current bit index (input-switch mux select)
o_con_mux  out  1  1 = load GPR from switches
o_con_muxalu  out  1  1 = ALU sign/pass path
o_con_gpr_shift, o_con_acc_shift  out  1 each  shift strobes
o_con_gpr_sign, o_con_acc_sign  out  1 each  sign-extend mode
o_con_sign_store  out  1  capture operand sign bit
o_con_pcincr  out  1  retire instruction, PC+1
o_phase  out  2  multiply phase (PH_SIGN/PH_ALIGN/PH_MUL)
o_busy  out  1  sequence in progress

Behaviour:
Opcodes:
- 000 NOP_WAIT_START
- 001 STALL
- 010 MUL_D
- 011 MUL_1MD
- 10x ADD
- 110 WAIT_RELEASE
- 111 LOAD

State and reset:
- State is cnt (CNT_W bits) and phase.
- i_rst asynchronously sets cnt=0 and phase=PH_SIGN, including mid-operation.
- o_bit_sel=cnt, o_phase=phase, o_busy = (phase!=PH_SIGN)|(cnt!=0).
- o_busy, o_bit_sel and o_phase are all 0 in reset.
- All o_con_* are combinational from (i_instr, phase, cnt) and ANDed with i_en. With i_en=0 every o_con_* is 0 and cnt/phase hold.
- last = (cnt==DATA_W-1).

Counter:
- On an enabled cycle of MUL/ADD/LOAD: cnt <= last ? 0 : cnt+1.
- Explicit wrap is required for non-power-of-2 DATA_W.
- NOP_WAIT_START, STALL and WAIT_RELEASE clear cnt whenever they assert pcincr.

NOP_WAIT_START:
- pcincr=1 when i_start=1, else idle.

STALL:
- pcincr=1 unconditionally.

WAIT_RELEASE:
- pcincr=1 when i_start=0.

ADD:
- gpr_shift=acc_shift=1; mux=muxalu=0.
- pcincr at last.
- Latency DATA_W enabled cycles.

LOAD:
- mux=1, gpr_shift=1.
- pcincr at last.

MUL_D / MUL_1MD, 3*DATA_W enabled cycles:
- PH_SIGN:
  - muxalu=1, gpr_shift=acc_shift=1, signs 0.
  - sign_store=1 at last.
  - At last, phase -> PH_ALIGN.
- PH_ALIGN:
  - gpr_sign=acc_sign=1.
  - gpr_shift=(cnt<ALIGN_GPR_op), where ALIGN_GPR_op is ALIGN_GPR_D for MUL_D and ALIGN_GPR_1MD for MUL_1MD.
  - acc_shift=(cnt<ALIGN_ACC).
  - At last, phase -> PH_MUL.
- PH_MUL:
  - muxalu=0, gpr_shift=acc_shift=1, signs 0.
  - pcincr at last.
  - At last, phase -> PH_SIGN.

Other phase rules:
- Any enabled cycle with a non-MUL opcode forces phase=PH_SIGN.
- phase encoding 2'b10 is illegal. If reached, it is treated as PH_SIGN and phase is corrected to PH_SIGN on the next enabled cycle.
- pcincr and sign_store are single-cycle pulses per enabled cycle.
- pcincr is never asserted together with sign_store.

Decomposition:
- Package serial_pkg:
  - opcode localparams (OP_NOP, OP_STALL, OP_MUL_D, OP_MUL_1MD, OP_ADD, OP_WAIT_REL, OP_LOAD);
  - phase enum (PH_SIGN=2'b00, PH_ALIGN=2'b01, PH_MUL=2'b11).
- One sub-module, bit_counter: parameter DATA_W; inputs i_clk, i_rst, i_en, i_clr; outputs o_cnt, o_last; wraps at DATA_W-1.
- Phase FSM and output decode live in serial_seq_ctrl.

Test Plan:
- Reset, then LOAD with i_en=1 and DATA_W=8: o_bit_sel steps 0..7 with o_con_mux=1 every cycle; pcincr only on the 8th cycle; o_bit_sel then returns to 0.
- MUL_D with DATA_W=8 for 24 enabled cycles:
  - sign_store on cycle 8;
  - align gpr_shift on cycles 9-10 and acc_shift on cycles 9-11, with both signs 1 for cycles 9-16;
  - pcincr on cycle 24; o_phase sequence 00,01,11,00.
- MUL_1MD with i_en toggling 1,0,1,0: all o_con_* are 0 on disabled cycles; align gpr_shift occurs on exactly 1 enabled cycle; total of 24 enabled cycles to pcincr.
- Assert i_rst asynchronously mid-PH_ALIGN at cnt=3: o_phase=00, o_bit_sel=0 and o_busy=0 immediately, without waiting for a clock edge; a restart completes a full 24 cycles.
- DATA_W=6 build, ADD: cnt sequence 0..5 then 0; pcincr on the 6th cycle; no cnt value of 6 or 7 ever appears.
- NOP_WAIT_START with i_start=0 for 5 cycles: no pcincr; i_start=1 gives pcincr the same cycle. WAIT_RELEASE with i_start=1 holds off pcincr until i_start=0.
